// File: rtl/interval_timer_pkg.sv
// Shared types for the interval timer: FSM state encoding and mode constants.
// Pure declarations, no logic and no latency.
// Imported by the timer and by anything that needs to decode its state.
package timer_pkg;

  // Timer FSM states.
  //   IDLE : interval loaded, not yet started
  //   RUN  : counting ticks
  //   HALT : paused, count frozen
  //   DONE : one-shot interval finished
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2,
    DONE = 2'd3
  } timer_state_e;

  // Encoding of the mode input.
  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage : timer_pkg

// File: rtl/interval_timer.sv
// Programmable down-counting interval timer, fed by the prescaler's carry-out on tick.
// Latency: expire is combinational in the tick cycle; cnt/busy/irq update on the next edge.
// No backpressure: requests are single-cycle pulses with fixed priority load > stop > start.
module interval_timer
  import timer_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          load,
  input  logic [DW-1:0] load_val,
  input  logic          start,
  input  logic          stop,
  input  logic          mode,
  input  logic          irq_clr,
  output logic [DW-1:0] cnt,
  output logic          busy,
  output logic          expire,
  output logic          irq
);

  localparam logic [DW-1:0] CNT_ZERO = '0;
  localparam logic [DW-1:0] CNT_ONE  = DW'(1);

  timer_state_e  state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] reload_q, reload_d;
  logic          irq_q, irq_d;
  logic          expire_d;

  // Qualified requests: a higher-priority request masks the lower ones.
  logic start_req;
  logic stop_req;
  assign stop_req  = stop & ~load;
  assign start_req = start & ~load & ~stop;

  // Next-state logic: request handling, tick counting and expiry detection.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    expire_d = 1'b0;

    if (load) begin
      // Load aborts any run; a same-cycle tick is dropped.
      reload_d = load_val;
      cnt_d    = load_val;
      state_d  = IDLE;
    end else begin
      unique case (state_q)
        IDLE, HALT: begin
          // A zero count can never expire, so refuse to start it.
          if (start_req && (cnt_q != CNT_ZERO)) begin
            state_d = RUN;
          end
        end

        DONE: begin
          // Restart a finished one-shot from the stored interval.
          if (start_req && (reload_q != CNT_ZERO)) begin
            cnt_d   = reload_q;
            state_d = RUN;
          end
        end

        RUN: begin
          if (stop_req) begin
            // Pause wins over a same-cycle tick; the count is frozen.
            state_d = HALT;
          end else if (tick) begin
            if (cnt_q > CNT_ONE) begin
              cnt_d = cnt_q - CNT_ONE;
            end else if (cnt_q == CNT_ONE) begin
              expire_d = 1'b1;
              if (mode == MODE_ONESHOT) begin
                cnt_d   = CNT_ZERO;
                state_d = DONE;
              end else begin
                // Reload directly so the period is exactly reload ticks.
                cnt_d = reload_q;
              end
            end
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Sticky interrupt: a new expiry takes precedence over a clear.
  always_comb begin
    irq_d = irq_q;
    if (expire_d) begin
      irq_d = 1'b1;
    end else if (irq_clr) begin
      irq_d = 1'b0;
    end
  end

  // State, count, reload and irq registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= CNT_ZERO;
      reload_q <= CNT_ZERO;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      irq_q    <= irq_d;
    end
  end

  assign cnt    = cnt_q;
  assign busy   = (state_q == RUN);
  assign expire = expire_d;
  assign irq    = irq_q;

endmodule : interval_timer

// File: tb/tb_interval_timer.sv
// Directed bench for interval_timer: one-shot, periodic, pause/resume, priority,
// zero-load / DONE restart, irq set/clear race and asynchronous reset.
// Inputs change 1 time unit after the rising edge; outputs are checked away from the edge.
module tb_interval_timer;
  import timer_pkg::*;

  localparam int DW = 16;

  logic          clk;
  logic          rst;
  logic          tick;
  logic          load;
  logic [DW-1:0] load_val;
  logic          start;
  logic          stop;
  logic          mode;
  logic          irq_clr;
  logic [DW-1:0] cnt;
  logic          busy;
  logic          expire;
  logic          irq;

  int checks = 0;
  int errors = 0;

  interval_timer #(.DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .irq_clr  (irq_clr),
    .cnt      (cnt),
    .busy     (busy),
    .expire   (expire),
    .irq      (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and drop all single-cycle requests.
  task automatic step();
    @(posedge clk);
    #1;
    tick    = 1'b0;
    load    = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    irq_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; load = 1'b0; load_val = '0;
    start = 1'b0; stop = 1'b0; mode = 1'b0; irq_clr = 1'b0;

    // Reset state
    #2;
    chk("rst_cnt",    32'(cnt),     0);
    chk("rst_state",  32'(dut.state_q), 32'(IDLE));
    chk("rst_busy",   32'(busy),    0);
    chk("rst_expire", 32'(expire),  0);
    chk("rst_irq",    32'(irq),     0);
    #5 rst = 1'b0;
    @(posedge clk);
    #1;

    // One-shot: interval 3, tick every 4th cycle
    mode = MODE_ONESHOT; load_val = 16'd3; load = 1'b1;
    step();
    chk("os_load_cnt",   32'(cnt), 3);
    chk("os_load_state", 32'(dut.state_q), 32'(IDLE));
    chk("os_load_busy",  32'(busy), 0);
    start = 1'b1;
    step();
    chk("os_start_busy", 32'(busy), 1);
    for (int k = 1; k <= 3; k++) begin
      repeat (3) begin
        #1 chk("os_idle_expire", 32'(expire), 0);
        step();
      end
      tick = 1'b1;
      #1 chk("os_tick_expire", 32'(expire), (k == 3) ? 1 : 0);
      step();
      chk("os_cnt", 32'(cnt), 32'(3 - k));
    end
    chk("os_done_state", 32'(dut.state_q), 32'(DONE));
    chk("os_done_busy",  32'(busy), 0);
    chk("os_done_irq",   32'(irq), 1);

    // Periodic: interval 2, tick every cycle
    irq_clr = 1'b1; mode = MODE_PERIODIC; load_val = 16'd2; load = 1'b1;
    step();
    chk("per_irq_clr", 32'(irq), 0);
    start = 1'b1;
    step();
    for (int i = 1; i <= 6; i++) begin
      chk("per_cnt", 32'(cnt), (i % 2 == 1) ? 2 : 1);
      tick = 1'b1;
      #1 chk("per_expire", 32'(expire), (i % 2 == 0) ? 1 : 0);
      step();
      chk("per_busy", 32'(busy), 1);
    end
    chk("per_cnt_end", 32'(cnt), 2);

    // Pause / resume
    mode = MODE_ONESHOT; irq_clr = 1'b1; load_val = 16'd5; load = 1'b1;
    step();
    start = 1'b1;
    step();
    repeat (2) begin
      tick = 1'b1;
      step();
    end
    chk("pr_cnt_run", 32'(cnt), 3);
    stop = 1'b1; tick = 1'b1;
    #1 chk("pr_stop_expire", 32'(expire), 0);
    step();
    chk("pr_halt_cnt",   32'(cnt), 3);
    chk("pr_halt_state", 32'(dut.state_q), 32'(HALT));
    chk("pr_halt_busy",  32'(busy), 0);
    repeat (3) begin
      tick = 1'b1;
      step();
    end
    chk("pr_halt_hold", 32'(cnt), 3);
    start = 1'b1;
    step();
    chk("pr_resume_busy", 32'(busy), 1);
    for (int k = 1; k <= 3; k++) begin
      tick = 1'b1;
      #1 chk("pr_expire", 32'(expire), (k == 3) ? 1 : 0);
      step();
    end
    chk("pr_done_state", 32'(dut.state_q), 32'(DONE));
    chk("pr_done_cnt",   32'(cnt), 0);
    chk("pr_done_irq",   32'(irq), 1);

    // Priority: load beats stop and tick at cnt == 1
    irq_clr = 1'b1; load_val = 16'd2; load = 1'b1;
    step();
    chk("pri_irq_clr", 32'(irq), 0);
    start = 1'b1;
    step();
    tick = 1'b1;
    step();
    chk("pri_cnt1", 32'(cnt), 1);
    load_val = 16'd7; load = 1'b1; stop = 1'b1; tick = 1'b1;
    #1 chk("pri_expire", 32'(expire), 0);
    step();
    chk("pri_cnt",   32'(cnt), 7);
    chk("pri_state", 32'(dut.state_q), 32'(IDLE));
    chk("pri_irq",   32'(irq), 0);

    // Zero load never starts; DONE restart from reload value
    load_val = 16'd0; load = 1'b1;
    step();
    start = 1'b1;
    step();
    chk("zero_state", 32'(dut.state_q), 32'(IDLE));
    chk("zero_busy",  32'(busy), 0);
    load_val = 16'd4; load = 1'b1;
    step();
    start = 1'b1;
    step();
    repeat (4) begin
      tick = 1'b1;
      step();
    end
    chk("dr_done_state", 32'(dut.state_q), 32'(DONE));
    chk("dr_done_cnt",   32'(cnt), 0);
    start = 1'b1;
    step();
    chk("dr_restart_cnt",   32'(cnt), 4);
    chk("dr_restart_state", 32'(dut.state_q), 32'(RUN));
    chk("dr_restart_busy",  32'(busy), 1);

    // irq set/clear race
    irq_clr = 1'b1;
    step();
    chk("race_pre_clr", 32'(irq), 0);
    repeat (3) begin
      tick = 1'b1;
      step();
    end
    chk("race_cnt1", 32'(cnt), 1);
    tick = 1'b1; irq_clr = 1'b1;
    #1 chk("race_expire", 32'(expire), 1);
    step();
    chk("race_irq_set", 32'(irq), 1);
    irq_clr = 1'b1;
    step();
    chk("race_irq_clr", 32'(irq), 0);

    // Asynchronous reset mid-run with irq pending
    load_val = 16'd1; load = 1'b1;
    step();
    start = 1'b1;
    step();
    tick = 1'b1;
    step();
    chk("ar_irq_pending", 32'(irq), 1);
    load_val = 16'd9; load = 1'b1;
    step();
    start = 1'b1;
    step();
    chk("ar_run_cnt",  32'(cnt), 9);
    chk("ar_run_busy", 32'(busy), 1);
    #1 rst = 1'b1;
    #1;
    chk("ar_cnt",   32'(cnt), 0);
    chk("ar_state", 32'(dut.state_q), 32'(IDLE));
    chk("ar_busy",  32'(busy), 0);
    chk("ar_irq",   32'(irq), 0);
    #1 rst = 1'b0;
    step();
    chk("ar_post_state", 32'(dut.state_q), 32'(IDLE));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_interval_timer
